// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: NOP word, datapath bubble control word, hazard FSM states.
package rv32i_types;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops;

  typedef struct packed {
    logic       load_regfile;
    logic       dcache_read;
    logic       dcache_write;
    logic [3:0] mem_byte_enable;
    alu_ops     aluop;
  } rv32i_control_word;

  // Selected into ID/EX by the datapath when bubble_id_ex is high.
  localparam rv32i_control_word BUBBLE_CTRL = '{
    load_regfile:    1'b0,
    dcache_read:     1'b0,
    dcache_write:    1'b0,
    mem_byte_enable: 4'b1111,
    aluop:           alu_add
  };

  typedef enum logic {RUN, FROZEN} hazard_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall-cycle and bubble counters for the hazard controller.
module hazard_perf_counters
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc_i,
  input  logic [1:0]       bubble_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] bubble_count_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W:0]   stall_sum, bubble_sum;

  // One extra bit catches the carry so the count pins at all-ones instead of wrapping.
  always_comb begin
    stall_sum  = {1'b0, stall_q} + {{CNT_W{1'b0}}, stall_inc_i};
    bubble_sum = {1'b0, bubble_q} + {{(CNT_W-1){1'b0}}, bubble_inc_i};
    stall_d    = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
    bubble_d   = bubble_sum[CNT_W] ? {CNT_W{1'b1}} : bubble_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign bubble_count_o = bubble_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes on cache misses, bubbles load-use, squashes on taken branch.
// Stage loads are combinational from this cycle's inputs; only miss bookkeeping is registered.
module pipeline_hazard_ctrl #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic [31:0]      icache_rdata,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  output logic             icache_read_en,
  output logic [31:0]      instr_out,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             squash_if_id,
  output logic             bubble_id_ex,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  import rv32i_types::*;

  hazard_state_e state_q, state_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [31:0]   ibuf_q, ibuf_d;

  logic          i_pend, d_pend, freeze, load_use;
  logic          stall_inc;
  logic [1:0]    bubble_inc;

  always_comb begin
    state_d        = state_q;
    i_done_d       = i_done_q;
    d_done_d       = d_done_q;
    ibuf_d         = ibuf_q;
    icache_read_en = 1'b0;
    instr_out      = '0;
    load_pc        = 1'b0;
    load_if_id     = 1'b0;
    load_id_ex     = 1'b0;
    load_ex_mem    = 1'b0;
    load_mem_wb    = 1'b0;
    squash_if_id   = 1'b0;
    bubble_id_ex   = 1'b0;
    pc_redirect    = 1'b0;
    stall_inc      = 1'b0;
    bubble_inc     = 2'd0;

    i_pend   = icache_read & ~icache_resp & ~i_done_q;
    d_pend   = dcache_req & ~dcache_resp & ~d_done_q;
    freeze   = i_pend | d_pend;
    load_use = ex_is_load & (ex_rd != 5'd0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    if (!rst) begin
      // Once the fetch has completed, hold off re-requesting it until release.
      icache_read_en = icache_read & ~i_done_q;
      instr_out      = i_done_q ? ibuf_q : icache_rdata;

      if (freeze) begin
        state_d   = FROZEN;
        stall_inc = 1'b1;
        if (icache_resp & d_pend) begin
          i_done_d = 1'b1;
          ibuf_d   = icache_rdata;
        end
        if (dcache_resp & i_pend) begin
          d_done_d = 1'b1;
        end
      end else begin
        if (state_q == FROZEN) begin
          i_done_d = 1'b0;
          d_done_d = 1'b0;
        end
        state_d     = RUN;
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        // A taken branch squashes the ID instruction, so its load-use match is moot.
        if (ex_br_taken) begin
          pc_redirect  = 1'b1;
          squash_if_id = 1'b1;
          bubble_id_ex = 1'b1;
          bubble_inc   = 2'd2;
        end else if (load_use) begin
          load_pc      = 1'b0;
          load_if_id   = 1'b0;
          bubble_id_ex = 1'b1;
          bubble_inc   = 2'd1;
        end
      end
    end
  end

  // The buffer is only read while i_done is set, so its reset value is never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      ibuf_q   <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      ibuf_q   <= ibuf_d;
    end
  end

  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .stall_inc_i   (stall_inc),
    .bubble_inc_i  (bubble_inc),
    .stall_cycles_o(stall_cycles),
    .bubble_count_o(bubble_count)
  );

endmodule
